mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one multi-cycle backing memory port between the hart's instruction-fetch requester and its data (load/store) requester.
- Replaces the combinational imem/dmem model used in the single-cycle phase.
- Accepts one request at a time, holds it until the memory accepts it, waits for the memory response, then returns the response to the owning requester.
- Sits between the hart's fetch/memory stages and the memory model.

Parameters:
- DATA_PRIORITY, 0, 0 = round-robin arbitration; 1 = fixed priority, data always wins ties.

Ports:
- i_clk  in  1  global clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_imem_req  in  1  fetch request pending; held stable until o_imem_ready.
- i_imem_addr  in  32  fetch address.
- o_imem_ready  out  1  fetch request accepted this cycle.
- o_imem_valid  out  1  fetch response valid; 1-cycle pulse.
- o_imem_rdata  out  32  fetched instruction word.
- i_dmem_req  in  1  data request pending; held stable until o_dmem_ready.
- i_dmem_wen  in  1  1 = store, 0 = load.
- i_dmem_addr  in  32  data address.
- i_dmem_wdata  in  32  store data, already lane-shifted.
- i_dmem_mask  in  4  byte-lane mask.
- o_dmem_ready  out  1  data request accepted this cycle.
- o_dmem_valid  out  1  data response or store acknowledge; 1-cycle pulse.
- o_dmem_rdata  out  32  load data; 0 for stores.
- o_mem_req  out  1  request to memory.
- o_mem_wen  out  1  write enable to memory.
- o_mem_addr  out  32  word-aligned address to memory.
- o_mem_wdata  out  32  write data to memory.
- o_mem_mask  out  4  byte mask to memory; 4'b1111 for fetches.
- i_mem_ready  in  1  memory accepted o_mem_req this cycle.
- i_mem_valid  in  1  memory response valid; also issued for writes.
- i_mem_rdata  in  32  memory read data.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - All outputs = 0.
  - Latched request registers = 0.
  - Round-robin pointer last_grant = IMEM, so data wins the first tie.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Grant is combinational.
  - If only one requester is pending, grant it.
  - If both are pending and DATA_PRIORITY=1, grant data.
  - If both are pending and DATA_PRIORITY=0, grant the requester that is not last_grant.
  - The winner's o_*_ready = 1 in that same cycle. The loser's ready stays 0 and it must keep holding its request.
  - On a grant, latch addr/wen/wdata/mask and the owner, update last_grant, and go to REQ.
  - Fetch grants latch wen=0 and mask=4'b1111.
- Latched address: stored with bits [1:0] forced to 0.
- REQ:
  - o_mem_req = 1 and o_mem_* are driven from the latched registers.
  - Stay in REQ until i_mem_ready = 1, then go to WAIT.
- WAIT:
  - o_mem_req = 0.
  - i_mem_valid is ignored in the same cycle as i_mem_ready; the earliest accepted response is in the first WAIT cycle.
  - On i_mem_valid, register i_mem_rdata (loads and fetches) or 0 (stores) into the owner's rdata and go to RESP.
  - There is no timeout; WAIT is unbounded.
- RESP:
  - The owner's o_*_valid = 1 for exactly this cycle; the other requester's valid = 0.
  - Go to IDLE.
  - No grant is issued in RESP.
- o_*_rdata: holds its last value until the next response to the same requester.
- Minimum latency: accept in cycle N, o_mem_req in N+1 (ready=1), i_mem_valid in N+2, o_*_valid in N+3.
- Back-to-back: the next grant can occur in the IDLE cycle that follows RESP. Minimum issue interval is 4 cycles.
- Stray inputs: i_mem_valid in IDLE/REQ/RESP and i_mem_ready outside REQ are ignored.
- Reset mid-transaction: the in-flight transaction is abandoned, no response pulse is issued, and a late i_mem_valid after reset is ignored.
- At most one outstanding memory transaction at any time.
- o_imem_ready and o_dmem_ready are never both 1.

Test Plan:
- Fetch only: i_imem_req with addr 0x00000104, memory ready at the first REQ cycle, valid one cycle later with rdata 0x00A00093 -> o_mem_addr = 0x00000104, o_mem_mask = 4'b1111, o_imem_valid pulse exactly 3 cycles after ready with rdata 0x00A00093.
- Store: dmem wen=1, addr 0x00002003, mask 4'b1000, wdata 0xAB000000 -> o_mem_addr = 0x00002000, o_mem_wen = 1, o_mem_mask = 4'b1000; after the valid ack, o_dmem_valid pulses with o_dmem_rdata = 0.
- Tie, DATA_PRIORITY=0: both requesters held continuously from reset for 4 transactions -> grant order dmem, imem, dmem, imem; the non-winner's ready is never asserted while waiting.
- Tie, DATA_PRIORITY=1: both held for 3 transactions -> dmem granted every time, imem never ready.
- Stalled memory: i_mem_ready held low for 5 cycles then high, then i_mem_valid after 7 cycles -> o_mem_req high for exactly 6 cycles with stable fields, then exactly one valid pulse; stray i_mem_valid during REQ ignored.
- Asynchronous reset asserted during WAIT, then i_mem_valid after reset release -> all outputs 0 immediately, no o_*_valid pulse, state IDLE, next tie goes to dmem.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between the fetch and data requesters.
// One transaction in flight at a time: IDLE -> REQ -> WAIT -> RESP, so a new grant comes at most every 4 cycles.
module mem_arbiter #(
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_req,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_ready,
  output logic        o_imem_valid,
  output logic [31:0] o_imem_rdata,
  input  logic        i_dmem_req,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IMEM = 1'b0;
  localparam logic OWN_DMEM = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic pick_dmem;
  logic gnt_imem;
  logic gnt_dmem;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{i_imem_addr[1:0], i_dmem_addr[1:0]};

  // Data wins a tie under fixed priority, or under round-robin when fetch was served last.
  always_comb begin
    pick_dmem = i_dmem_req &&
                (!i_imem_req || (DATA_PRIORITY != 0) || (last_grant_q == OWN_IMEM));
    gnt_dmem  = (state_q == S_IDLE) && pick_dmem;
    gnt_imem  = (state_q == S_IDLE) && i_imem_req && !pick_dmem;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_dmem) begin
          owner_d      = OWN_DMEM;
          last_grant_d = OWN_DMEM;
          addr_d       = {i_dmem_addr[31:2], 2'b00};
          wen_d        = i_dmem_wen;
          wdata_d      = i_dmem_wdata;
          mask_d       = i_dmem_mask;
          state_d      = S_REQ;
        end else if (gnt_imem) begin
          owner_d      = OWN_IMEM;
          last_grant_d = OWN_IMEM;
          addr_d       = {i_imem_addr[31:2], 2'b00};
          wen_d        = 1'b0;
          wdata_d      = 32'd0;
          mask_d       = 4'b1111;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (i_mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_valid) begin
          if (owner_q == OWN_DMEM) drdata_d = wen_q ? 32'd0 : i_mem_rdata;
          else                     irdata_d = i_mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IMEM;
      last_grant_q <= OWN_IMEM;
      addr_q       <= 32'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'd0;
      mask_q       <= 4'd0;
      irdata_q     <= 32'd0;
      drdata_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  assign o_imem_ready = gnt_imem;
  assign o_dmem_ready = gnt_dmem;
  assign o_imem_valid = (state_q == S_RESP) && (owner_q == OWN_IMEM);
  assign o_dmem_valid = (state_q == S_RESP) && (owner_q == OWN_DMEM);
  assign o_imem_rdata = irdata_q;
  assign o_dmem_rdata = drdata_q;

  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued at issue time and
// popped by a monitor at grant, memory accept and response.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        imem_req, dmem_req, dmem_wen, mem_ready, mem_valid;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  dmem_mask;
  wire         imem_ready, imem_valid, dmem_ready, dmem_valid, mem_req, mem_wen;
  wire  [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  wire  [3:0]  mem_mask;

  mem_arbiter #(.DATA_PRIORITY(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req(imem_req), .i_imem_addr(imem_addr),
    .o_imem_ready(imem_ready), .o_imem_valid(imem_valid), .o_imem_rdata(imem_rdata),
    .i_dmem_req(dmem_req), .i_dmem_wen(dmem_wen), .i_dmem_addr(dmem_addr),
    .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
    .o_dmem_ready(dmem_ready), .o_dmem_valid(dmem_valid), .o_dmem_rdata(dmem_rdata),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata)
  );

  // Fixed-priority instance: both requesters share one request line, memory always ready.
  logic        p1_req = 1'b0;
  logic        p1_mem_ready = 1'b1;
  logic        p1_mem_valid = 1'b1;
  wire         p1_imem_ready, p1_imem_valid, p1_dmem_ready, p1_dmem_valid, p1_mem_req, p1_mem_wen;
  wire  [31:0] p1_imem_rdata, p1_dmem_rdata, p1_mem_addr, p1_mem_wdata;
  wire  [3:0]  p1_mem_mask;

  mem_arbiter #(.DATA_PRIORITY(1)) dut_p1 (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req(p1_req), .i_imem_addr(32'h0000_0040),
    .o_imem_ready(p1_imem_ready), .o_imem_valid(p1_imem_valid), .o_imem_rdata(p1_imem_rdata),
    .i_dmem_req(p1_req), .i_dmem_wen(1'b0), .i_dmem_addr(32'h0000_0080),
    .i_dmem_wdata(32'h0), .i_dmem_mask(4'hF),
    .o_dmem_ready(p1_dmem_ready), .o_dmem_valid(p1_dmem_valid), .o_dmem_rdata(p1_dmem_rdata),
    .o_mem_req(p1_mem_req), .o_mem_wen(p1_mem_wen), .o_mem_addr(p1_mem_addr),
    .o_mem_wdata(p1_mem_wdata), .o_mem_mask(p1_mem_mask),
    .i_mem_ready(p1_mem_ready), .i_mem_valid(p1_mem_valid), .i_mem_rdata(32'h5A5A_5A5A)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Memory contents seen by loads and fetches: a fixed function of the word address.
  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  typedef struct packed {
    logic        own;     // 0 = fetch, 1 = data
    logic [31:0] raw;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
  } txn_t;

  logic grant_q[$];
  txn_t memq[$];
  txn_t respq[$];
  bit   last_d = 1'b0;  // model: was the last grant to data?

  function automatic void push_txn(txn_t t);
    grant_q.push_back(t.own);
    memq.push_back(t);
    respq.push_back(t);
  endfunction

  // ---------------- monitor ----------------
  int   req_cycles = 0, ivalid_cnt = 0, dvalid_cnt = 0;
  int   p1_dv_cnt = 0, p1_iv_cnt = 0, p1_ir_cnt = 0;
  logic prev_req = 1'b0, prev_rdy = 1'b0, prev_wen = 1'b0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;
  logic [3:0]  prev_mask = 0;
  txn_t mon_t;
  logic mon_g;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      p1_dv_cnt += int'(p1_dmem_valid);
      p1_iv_cnt += int'(p1_imem_valid);
      p1_ir_cnt += int'(p1_imem_ready);
      chk("ready_exclusive", imem_ready & dmem_ready, 0);
      if (imem_ready || dmem_ready) begin
        if (grant_q.size() == 0) chk("unexpected_grant", {dmem_ready, imem_ready}, 0);
        else begin
          mon_g = grant_q.pop_front();
          chk("grant_owner", dmem_ready, mon_g);
        end
      end
      if (mem_req) begin
        req_cycles++;
        if (prev_req && !prev_rdy) begin
          chk("stall_addr_stable", mem_addr, prev_addr);
          chk("stall_ctl_stable", {mem_wen, mem_mask}, {prev_wen, prev_mask});
          chk("stall_wdata_stable", mem_wdata, prev_wdata);
        end
        if (mem_ready) begin
          if (memq.size() == 0) chk("unexpected_mem_accept", mem_addr, 32'hFFFF_FFFF);
          else begin
            mon_t = memq.pop_front();
            chk("mem_addr", mem_addr, mon_t.addr);
            chk("mem_wen", mem_wen, mon_t.wen);
            chk("mem_mask", mem_mask, mon_t.mask);
            if (mon_t.wen) chk("mem_wdata", mem_wdata, mon_t.wdata);
          end
        end
      end
      prev_req = mem_req; prev_rdy = mem_ready; prev_wen = mem_wen;
      prev_addr = mem_addr; prev_wdata = mem_wdata; prev_mask = mem_mask;
      ivalid_cnt += int'(imem_valid);
      dvalid_cnt += int'(dmem_valid);
      if (imem_valid || dmem_valid) begin
        chk("valid_exclusive", imem_valid & dmem_valid, 0);
        if (respq.size() == 0) chk("unexpected_valid", {dmem_valid, imem_valid}, 0);
        else begin
          mon_t = respq.pop_front();
          chk("resp_owner", dmem_valid, mon_t.own);
          chk("resp_rdata", mon_t.own ? dmem_rdata : imem_rdata, mon_t.rdata);
        end
      end
    end
  end

  // ---------------- random memory responder ----------------
  bit mem_auto = 1'b0;

  initial begin : mem_drv
    int phase, stall, lat;
    logic [31:0] a;
    phase = 0; stall = 0; lat = 0; a = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !mem_auto) phase = 0;
      else begin
        mem_ready = 1'b0;
        mem_valid = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        if (phase == 0 && mem_req) begin
          phase = 1;
          stall = $urandom_range(0, 3);
        end
        if (phase == 1) begin
          if (stall > 0) stall--;
          else begin
            mem_ready = 1'b1; a = mem_addr; lat = $urandom_range(0, 3); phase = 2;
          end
        end else if (phase == 2) begin
          mem_valid = 1'b0;
          mem_ready = ($urandom_range(0, 3) == 0);
          if (lat > 0) lat--;
          else begin
            mem_valid = 1'b1; mem_rdata = memf(a); phase = 0;
          end
        end else begin
          mem_ready = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic check_zero(string tag);
    chk({tag, "_ctl"}, {imem_ready, imem_valid, dmem_ready, dmem_valid, mem_req, mem_wen}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_mask"}, mem_mask, 0);
    chk({tag, "_imem_rdata"}, imem_rdata, 0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 0);
  endtask

  // Each requester issues its transactions back to back, re-raising as soon as it is accepted.
  task automatic drive(int ni, int nd);
    txn_t li[$], ld[$], t;
    int ri, rd, gi, gdn, bud;
    bit pick_d, ri_s, rd_s;
    for (int k = 0; k < ni; k++) begin
      t.own = 1'b0; t.raw = $urandom; t.addr = {t.raw[31:2], 2'b00};
      t.wen = 1'b0; t.wdata = 32'd0; t.mask = 4'hF; t.rdata = memf(t.addr);
      li.push_back(t);
    end
    for (int k = 0; k < nd; k++) begin
      t.own = 1'b1; t.raw = $urandom; t.addr = {t.raw[31:2], 2'b00};
      t.wen = $urandom_range(0, 1); t.wdata = $urandom; t.mask = 4'($urandom_range(1, 15));
      t.rdata = t.wen ? 32'd0 : memf(t.addr);
      ld.push_back(t);
    end
    ri = ni; rd = nd;
    while (ri > 0 || rd > 0) begin
      pick_d = (rd > 0) && (ri == 0 || !last_d);
      if (pick_d) begin push_txn(ld[nd - rd]); rd--; end
      else        begin push_txn(li[ni - ri]); ri--; end
      last_d = pick_d;
    end
    gi = 0; gdn = 0; bud = 0;
    @(posedge clk); #1;
    imem_req = (ni > 0); if (ni > 0) imem_addr = li[0].raw;
    dmem_req = (nd > 0);
    if (nd > 0) begin
      dmem_addr = ld[0].raw; dmem_wen = ld[0].wen; dmem_wdata = ld[0].wdata; dmem_mask = ld[0].mask;
    end
    while ((gi < ni || gdn < nd || respq.size() != 0) && bud < 400) begin
      @(negedge clk); ri_s = imem_ready; rd_s = dmem_ready;
      @(posedge clk); #1; bud++;
      if (ri_s) gi++;
      if (rd_s) gdn++;
      imem_req = (gi < ni);
      if (gi < ni) imem_addr = li[gi].raw;
      dmem_req = (gdn < nd);
      if (gdn < nd) begin
        dmem_addr = ld[gdn].raw; dmem_wen = ld[gdn].wen;
        dmem_wdata = ld[gdn].wdata; dmem_mask = ld[gdn].mask;
      end
    end
    if (bud >= 400) chk("drive_timeout", bud, 0);
    imem_req = 1'b0; dmem_req = 1'b0;
  endtask

  // One directed transaction with a hand-driven memory: stall cycles in REQ, lat cycles in WAIT.
  task automatic single(bit own, logic [31:0] raw, bit wen, logic [31:0] wdata, logic [3:0] mask,
                        int stall, int lat, bit stray, logic [31:0] mrd, string nm);
    txn_t t;
    int t0;
    t.own = own; t.raw = raw; t.addr = {raw[31:2], 2'b00}; t.wen = wen;
    t.wdata = wdata; t.mask = mask; t.rdata = wen ? 32'd0 : mrd;
    push_txn(t); last_d = own;
    req_cycles = 0; ivalid_cnt = 0; dvalid_cnt = 0;
    @(posedge clk); #1;
    if (own) begin
      dmem_req = 1'b1; dmem_addr = raw; dmem_wen = wen; dmem_wdata = wdata; dmem_mask = mask;
    end else begin
      imem_req = 1'b1; imem_addr = raw;
    end
    @(negedge clk);
    chk({nm, "_ready"}, own ? dmem_ready : imem_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    imem_req = 1'b0; dmem_req = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      mem_ready = (k == stall); mem_valid = stray; mem_rdata = 32'hBAD0_0000 | k;
      @(posedge clk); #1;
    end
    for (int k = 0; k <= lat; k++) begin
      mem_ready = stray && (k < lat); mem_valid = (k == lat);
      mem_rdata = (k == lat) ? mrd : 32'hBAD1_0000 | k;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, own ? dmem_valid : imem_valid, 1);
    chk({nm, "_latency"}, cyc - t0, stall + lat + 3);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_req_cycles"}, req_cycles, stall + 1);
    chk({nm, "_pulses"}, {ivalid_cnt[15:0], dvalid_cnt[15:0]}, own ? 32'h0000_0001 : 32'h0001_0000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, bud, lastg;
    imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_wen = 0; dmem_addr = 0;
    dmem_wdata = 0; dmem_mask = 0; mem_ready = 0; mem_valid = 0; mem_rdata = 0;
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Tie under round-robin straight out of reset: d, i, d, i.
    mem_auto = 1'b1;
    last_d = 1'b0;
    drive(2, 2);
    mem_auto = 1'b0;
    @(posedge clk); #1 mem_ready = 0; mem_valid = 0;
    repeat (2) @(posedge clk);

    single(1'b0, 32'h0000_0104, 1'b0, 32'd0, 4'hF, 0, 0, 1'b0, 32'h00A0_0093, "fetch");
    single(1'b1, 32'h0000_2003, 1'b1, 32'hAB00_0000, 4'b1000, 0, 0, 1'b0, 32'hDEAD_BEEF, "store");
    chk("imem_rdata_hold", imem_rdata, 32'h00A0_0093);
    single(1'b1, 32'h0000_3008, 1'b0, 32'd0, 4'hF, 5, 6, 1'b1, 32'h1357_9BDF, "stall");

    // Reset while the memory response is outstanding.
    imem_addr = 32'h0000_0500;
    begin
      txn_t t;
      t.own = 0; t.raw = imem_addr; t.addr = imem_addr; t.wen = 0; t.wdata = 0;
      t.mask = 4'hF; t.rdata = 32'h0;
      push_txn(t);
    end
    @(posedge clk); #1 imem_req = 1'b1;
    @(negedge clk); chk("rst_txn_ready", imem_ready, 1);
    @(posedge clk); #1 imem_req = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1 check_zero("midrst");
    respq.delete(); grant_q.delete(); memq.delete();
    last_d = 1'b0;
    ivalid_cnt = 0; dvalid_cnt = 0;
    @(posedge clk); #1 rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hBAD2_BAD2;
    @(posedge clk); #1 mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_no_valid", ivalid_cnt + dvalid_cnt, 0);

    // Round-robin tie again after reset, then random traffic.
    mem_auto = 1'b1;
    drive(2, 2);
    for (int s = 0; s < 40; s++) drive($urandom_range(0, 3), $urandom_range(0, 3));
    mem_auto = 1'b0;
    @(posedge clk); #1 mem_ready = 0; mem_valid = 0;

    // Fixed-priority instance: data wins every tie, fetch never accepted.
    p1_dv_cnt = 0; p1_iv_cnt = 0; p1_ir_cnt = 0;
    n = 0; bud = 0; lastg = -1;
    @(posedge clk); #1 p1_req = 1'b1;
    while (n < 3 && bud < 60) begin
      @(negedge clk); bud++;
      if (p1_dmem_ready) begin
        n++;
        if (lastg >= 0) chk("p1_issue_interval", cyc - lastg, 4);
        lastg = cyc;
      end
    end
    if (bud >= 60) chk("p1_timeout", bud, 0);
    @(posedge clk); #1 p1_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("p1_dmem_valids", p1_dv_cnt, 3);
    chk("p1_imem_ready", p1_ir_cnt, 0);
    chk("p1_imem_valid", p1_iv_cnt, 0);

    chk("queues_drained", grant_q.size() + memq.size() + respq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete by cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
